// File: rtl/comb_differencer_if.sv
// Valid/ready stream bundle for the comb differencer: input side, output side
// and the primed status flag.
interface comb_differencer_if #(
  parameter int WIDTH = 13
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_ovf;
  logic                    primed;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, primed
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, primed
  );
endinterface

// File: rtl/comb_differencer.sv
// Streaming comb stage y[n] = x[n] - x[n-DELAY] with one registered output
// stage, optional saturation and an overflow flag.
module comb_differencer #(
  parameter int WIDTH    = 13,
  parameter int DELAY    = 4,
  parameter int SATURATE = 1
) (
  input  logic                clk,
  input  logic                rst,
  comb_differencer_if.slave   bus
);
  localparam int                     CW       = $clog2(DELAY + 1);
  localparam logic [CW-1:0]          FILL_MAX = CW'(DELAY);
  localparam logic signed [WIDTH-1:0] MAX_V   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V   = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] r_dline [DELAY];
  logic [CW-1:0]           r_fill;
  logic                    r_out_valid;
  logic signed [WIDTH-1:0] r_out_data;
  logic                    r_out_ovf;

  logic                    w_in_ready;
  logic                    w_accept;
  logic signed [WIDTH-1:0] w_tail;
  logic [WIDTH:0]          w_diff;
  logic                    w_ovf;
  logic signed [WIDTH-1:0] w_result;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_tail     = r_dline[DELAY-1];

  // One extra bit holds the exact difference; overflow shows as the top two bits disagreeing.
  assign w_diff = {bus.in_data[WIDTH-1], bus.in_data} - {w_tail[WIDTH-1], w_tail};
  assign w_ovf  = w_diff[WIDTH] ^ w_diff[WIDTH-1];

  always_comb begin
    w_result = w_diff[WIDTH-1:0];
    if (w_ovf && (SATURATE != 0)) begin
      w_result = w_diff[WIDTH] ? MIN_V : MAX_V;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) begin
        r_dline[i] <= '0;
      end
      r_fill      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dline[0] <= bus.in_data;
        for (int i = 1; i < DELAY; i++) begin
          r_dline[i] <= r_dline[i-1];
        end
        r_out_data  <= w_result;
        r_out_ovf   <= w_ovf;
        r_out_valid <= 1'b1;
        if (r_fill != FILL_MAX) begin
          r_fill <= r_fill + 1'b1;
        end
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.primed    = (r_fill == FILL_MAX);
endmodule

// File: tb/tb_comb_differencer.sv
// Randomized and directed bench for comb_differencer; a saturating and a
// wrapping instance share stimulus and are checked against a sample-history model.
module tb_comb_differencer;
  localparam int W = 13;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comb_differencer_if #(.WIDTH(W)) bus_s ();
  comb_differencer_if #(.WIDTH(W)) bus_w ();

  comb_differencer #(.WIDTH(W), .DELAY(D), .SATURATE(1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s.slave)
  );

  comb_differencer #(.WIDTH(W), .DELAY(D), .SATURATE(0)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model: list of accepted samples since reset and the expected output register
  int hist[$];
  int m_valid  = 0;
  int m_data_s = 0;
  int m_data_w = 0;
  int m_ovf    = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input int d, input logic ordy);
    rst             = r;
    bus_s.in_valid  = v;
    bus_w.in_valid  = v;
    bus_s.in_data   = W'(d);
    bus_w.in_data   = W'(d);
    bus_s.out_ready = ordy;
    bus_w.out_ready = ordy;
  endtask

  task automatic check_outputs();
    int prim;
    prim = (hist.size() >= D) ? 1 : 0;
    chk("valid_s", int'(bus_s.out_valid), m_valid);
    chk("valid_w", int'(bus_w.out_valid), m_valid);
    chk("ready_s", int'(bus_s.in_ready), (m_valid == 0 || bus_s.out_ready) ? 1 : 0);
    chk("ready_w", int'(bus_w.in_ready), (m_valid == 0 || bus_w.out_ready) ? 1 : 0);
    chk("primed_s", int'(bus_s.primed), prim);
    chk("primed_w", int'(bus_w.primed), prim);
    chk("data_s", int'(bus_s.out_data), m_data_s);
    chk("data_w", int'(bus_w.out_data), m_data_w);
    chk("ovf_s", int'(bus_s.out_ovf), m_ovf);
    chk("ovf_w", int'(bus_w.out_ovf), m_ovf);
  endtask

  task automatic model_edge(input logic r, input logic v, input int d, input logic ordy);
    int sub, diff;
    if (r) begin
      hist.delete();
      m_valid = 0; m_data_s = 0; m_data_w = 0; m_ovf = 0;
    end else if (v && (m_valid == 0 || ordy)) begin
      sub  = (hist.size() >= D) ? hist[hist.size() - D] : 0;
      diff = d - sub;
      m_ovf    = (diff > 4095 || diff < -4096) ? 1 : 0;
      m_data_s = (diff > 4095) ? 4095 : (diff < -4096) ? -4096 : diff;
      m_data_w = ((diff + 4096 + 8192) % 8192) - 4096;
      m_valid  = 1;
      hist.push_back(d);
      if (hist.size() > D) void'(hist.pop_front());
    end else if (m_valid != 0 && ordy) begin
      m_valid = 0;
    end
  endtask

  // one clock: apply inputs, check at negedge, advance model, land #1 after the edge
  task automatic cyc(input logic r, input logic v, input int d, input logic ordy);
    drive(r, v, d, ordy);
    @(negedge clk);
    check_outputs();
    model_edge(r, v, d, ordy);
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int d);
    cyc(1'b0, 1'b1, d, 1'b1);
  endtask

  initial begin
    int rd, rv, rr, rx;
    drive(1'b1, 1'b0, 0, 1'b1);
    @(posedge clk); #1;
    cyc(1'b1, 1'b1, 123, 1'b1);

    // reset state
    chk("rst_valid", int'(bus_s.out_valid), 0);
    chk("rst_data", int'(bus_s.out_data), 0);
    chk("rst_primed", int'(bus_s.primed), 0);

    // impulse
    feed(100); feed(0); feed(0); feed(0);
    chk("imp_primed", int'(bus_s.primed), 1);
    feed(0);
    chk("imp_neg", int'(bus_s.out_data), -100);
    feed(0);
    cyc(1'b0, 1'b0, 0, 1'b1);

    // step with back-to-back accepts
    cyc(1'b1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 8; i++) feed(7);
    chk("step_zero", int'(bus_s.out_data), 0);

    // overflow high
    cyc(1'b1, 1'b0, 0, 1'b1);
    feed(-4096); feed(0); feed(0); feed(0); feed(4095);
    chk("ovh_sat", int'(bus_s.out_data), 4095);
    chk("ovh_wrap", int'(bus_w.out_data), -1);
    chk("ovh_flag", int'(bus_w.out_ovf), 1);

    // overflow low
    cyc(1'b1, 1'b0, 0, 1'b1);
    feed(4095); feed(0); feed(0); feed(0); feed(-4096);
    chk("ovl_sat", int'(bus_s.out_data), -4096);
    chk("ovl_wrap", int'(bus_w.out_data), 1);
    chk("ovl_flag", int'(bus_s.out_ovf), 1);

    // backpressure
    cyc(1'b1, 1'b0, 0, 1'b1);
    cyc(1'b0, 1'b1, 10, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 20, 1'b0);
    chk("bp_hold", int'(bus_s.out_data), 10);
    cyc(1'b0, 1'b1, 20, 1'b1);
    chk("bp_second", int'(bus_s.out_data), 20);
    cyc(1'b0, 1'b1, 30, 1'b1);
    chk("bp_third", int'(bus_s.out_data), 30);
    cyc(1'b0, 1'b0, 0, 1'b1);

    // reset mid-stream
    cyc(1'b1, 1'b0, 0, 1'b1);
    feed(50); feed(60);
    cyc(1'b1, 1'b1, 70, 1'b1);
    chk("mid_valid", int'(bus_s.out_valid), 0);
    chk("mid_primed", int'(bus_s.primed), 0);
    feed(5);
    chk("mid_fresh", int'(bus_s.out_data), 5);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rv = int'($urandom_range(0, 3));
      rr = int'($urandom_range(0, 3));
      rx = int'($urandom_range(0, 7));
      rd = (rx == 0) ? 4095 : (rx == 1) ? -4096 : int'($urandom_range(0, 8191)) - 4096;
      cyc(($urandom_range(0, 63) == 0), (rv != 0), rd, (rr != 0));
    end
    cyc(1'b0, 1'b0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
